multicycle_control_fsm: RTL and testbench

//  Main sequencer for the multi-cycle RV32I CPU. Walks each instruction through
//  IF/ID/EX/MEM/WB, drives the datapath mux selects, write enables and the 1-bit
//  ALU_op_sig into the ALU control unit (0 = force ADD, 1 = decode from IR).

---
 rtl/multicycle_control_fsm.sv | 216 +++++++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_fsm.sv
// Main sequencer for the multi-cycle RV32I CPU.
// Steps each instruction through IF/ID/EX/MEM/WB and decodes the datapath controls
// from the current state plus opcode/bcond/mem_ready. Memory states stretch on
// mem_ready; a stalled memory trips mem_error and parks the CPU in HALT.
module multicycle_control_fsm #(
    parameter int unsigned MEM_WAIT_LIMIT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic       bcond,
    input  logic       halt_req,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_source,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mdr_write,
    output logic       alu_out_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       ALU_op_sig,
    output logic       reg_write,
    output logic [1:0] wb_sel,
    output logic       retire,
    output logic       is_halted,
    output logic       mem_error
);

    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_ARITH     = 7'b0110011;
    localparam logic [6:0] OPC_ARITH_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

    localparam int CNT_W = (MEM_WAIT_LIMIT < 2) ? 1 : $clog2(MEM_WAIT_LIMIT + 1);

    typedef enum logic [2:0] {
        S_IF, S_ID, S_EX, S_MEM, S_WB, S_PC_INC, S_HALT
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] wait_q, wait_d;
    logic             mem_error_q, mem_error_d;
    logic             is_halted_q, is_halted_d;
    logic             in_mem_phase;
    logic             limit_hit;

    // Memory-wait watchdog: the limit trips on the cycle that would be the
    // MEM_WAIT_LIMIT-th consecutive not-ready cycle in IF or MEM.
    always_comb begin
        in_mem_phase = (state_q == S_IF) || (state_q == S_MEM);
        limit_hit    = (MEM_WAIT_LIMIT != 0) && in_mem_phase && !mem_ready &&
                       ((32'(wait_q) + 32'd1) >= MEM_WAIT_LIMIT);
    end

    // Next-state, wait counter and sticky flag update.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IF: begin
                if (limit_hit)      state_d = S_HALT;
                else if (mem_ready) state_d = S_ID;
            end
            S_ID: begin
                case (opcode)
                    OPC_SYSTEM:    state_d = halt_req ? S_HALT : S_PC_INC;
                    OPC_ARITH, OPC_ARITH_IMM, OPC_LOAD, OPC_STORE,
                    OPC_JALR, OPC_BRANCH, OPC_JAL:
                                   state_d = S_EX;
                    default:       state_d = S_PC_INC;
                endcase
            end
            S_EX: begin
                case (opcode)
                    OPC_ARITH, OPC_ARITH_IMM, OPC_JALR: state_d = S_WB;
                    OPC_LOAD, OPC_STORE:                state_d = S_MEM;
                    OPC_BRANCH:                         state_d = bcond ? S_IF : S_PC_INC;
                    OPC_JAL:                            state_d = S_IF;
                    default:                            state_d = S_PC_INC;
                endcase
            end
            S_MEM: begin
                if (limit_hit)      state_d = S_HALT;
                else if (mem_ready) state_d = (opcode == OPC_LOAD) ? S_WB : S_IF;
            end
            S_WB, S_PC_INC: state_d = S_IF;
            S_HALT:         state_d = S_HALT;
            default:        state_d = S_IF;
        endcase

        // Counter only runs while parked in the same memory state waiting;
        // any state change or a ready cycle starts it over from zero.
        wait_d = '0;
        if (in_mem_phase && !mem_ready && (state_d == state_q))
            wait_d = (wait_q == '1) ? wait_q : wait_q + CNT_W'(1);

        mem_error_d = mem_error_q | limit_hit;
        is_halted_d = is_halted_q | (state_d == S_HALT);
    end

    // State register and sticky flags; reset restarts fetch from IF.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IF;
            wait_q      <= '0;
            mem_error_q <= 1'b0;
            is_halted_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            mem_error_q <= mem_error_d;
            is_halted_q <= is_halted_d;
        end
    end

    // Datapath control decode; everything is held at zero while reset is high.
    always_comb begin
        pc_write      = 1'b0;
        pc_source     = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mdr_write     = 1'b0;
        alu_out_write = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        ALU_op_sig    = 1'b0;
        reg_write     = 1'b0;
        wb_sel        = 2'b00;
        retire        = 1'b0;
        is_halted     = is_halted_q && !reset;
        mem_error     = mem_error_q && !reset;
        if (!reset) begin
            case (state_q)
                S_IF: begin
                    mem_read = 1'b1;
                    ir_write = mem_ready;
                end
                S_ID: begin
                    alu_src_b     = 2'b10;
                    alu_out_write = 1'b1;
                end
                S_EX: begin
                    ALU_op_sig = 1'b1;
                    case (opcode)
                        OPC_ARITH: begin
                            alu_src_a     = 1'b1;
                            alu_out_write = 1'b1;
                        end
                        OPC_ARITH_IMM, OPC_LOAD, OPC_STORE, OPC_JALR: begin
                            alu_src_a     = 1'b1;
                            alu_src_b     = 2'b10;
                            alu_out_write = 1'b1;
                        end
                        OPC_BRANCH: begin
                            alu_src_a = 1'b1;
                            pc_source = 1'b1;
                            pc_write  = bcond;
                            retire    = bcond;
                        end
                        OPC_JAL: begin
                            ALU_op_sig = 1'b0;
                            alu_src_b  = 2'b01;
                            reg_write  = 1'b1;
                            wb_sel     = 2'b10;
                            pc_source  = 1'b1;
                            pc_write   = 1'b1;
                            retire     = 1'b1;
                        end
                        default: ALU_op_sig = 1'b0;
                    endcase
                end
                S_MEM: begin
                    i_or_d = 1'b1;
                    if (opcode == OPC_LOAD) begin
                        mem_read  = 1'b1;
                        mdr_write = mem_ready;
                    end else begin
                        mem_write = 1'b1;
                        if (mem_ready) begin
                            alu_src_b = 2'b01;
                            pc_write  = 1'b1;
                            retire    = 1'b1;
                        end
                    end
                end
                S_WB: begin
                    alu_src_b = 2'b01;
                    pc_write  = 1'b1;
                    retire    = 1'b1;
                    reg_write = 1'b1;
                    if (opcode == OPC_JALR) begin
                        wb_sel    = 2'b10;
                        pc_source = 1'b1;
                    end else if (opcode == OPC_LOAD) begin
                        wb_sel = 2'b01;
                    end
                end
                S_PC_INC: begin
                    alu_src_b = 2'b01;
                    pc_write  = 1'b1;
                    retire    = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench for multicycle_control_fsm: per-instruction expectations are
// queued when an instruction is driven and compared when the DUT retires it.
module tb_multicycle_control_fsm;

    logic       clk;
    logic       reset;
    logic [6:0] opcode;
    logic       bcond;
    logic       halt_req;
    logic       mem_ready;
    logic       pc_write, pc_source, i_or_d, mem_read, mem_write, ir_write, mdr_write;
    logic       alu_out_write, alu_src_a, ALU_op_sig, reg_write, retire;
    logic       is_halted, mem_error;
    logic [1:0] alu_src_b, wb_sel;
    logic [19:0] all_outs;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         cycles;
        int         mem_reads;
        int         ir_writes;
        int         aow;
        int         iod;
        int         mdr;
        int         mw;
        int         reg_writes;
        int         pc_writes;
        logic [1:0] wb_sel;
        logic       pc_src;
        logic [3:0] pcw_ctrl;
    } exp_t;

    exp_t sb_q[$];

    multicycle_control_fsm #(.MEM_WAIT_LIMIT(16)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .bcond(bcond),
        .halt_req(halt_req), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_source(pc_source), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mdr_write(mdr_write), .alu_out_write(alu_out_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .ALU_op_sig(ALU_op_sig),
        .reg_write(reg_write), .wb_sel(wb_sel), .retire(retire),
        .is_halted(is_halted), .mem_error(mem_error)
    );

    assign all_outs = {pc_write, pc_source, i_or_d, mem_read, mem_write, ir_write,
                       mdr_write, alu_out_write, alu_src_a, alu_src_b, ALU_op_sig,
                       reg_write, wb_sel, retire, is_halted, mem_error};

    // Free-running 10ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every comparison in the bench goes through here.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=0x%0h expected=0x%0h", tag, actual, expected);
        end
    endtask

    // Expected per-instruction totals for zero-based IF/MEM wait counts.
    function automatic exp_t expectFor(input logic [6:0] op, input logic bc, input int w_if, input int w_mem);
        exp_t e;
        e.cycles = w_if; e.mem_reads = w_if + 1; e.ir_writes = 1; e.aow = 1;
        e.iod = 0; e.mdr = 0; e.mw = 0; e.reg_writes = 0; e.pc_writes = 1;
        e.wb_sel = 2'b00; e.pc_src = 1'b0; e.pcw_ctrl = 4'b0010;
        case (op)
            7'h33, 7'h13: begin e.cycles += 4; e.reg_writes = 1; e.aow = 2; end
            7'h67: begin e.cycles += 4; e.reg_writes = 1; e.wb_sel = 2'b10; e.pc_src = 1'b1; e.aow = 2; end
            7'h03: begin
                e.cycles += 5 + w_mem; e.reg_writes = 1; e.wb_sel = 2'b01; e.aow = 2;
                e.mdr = 1; e.iod = 1 + w_mem; e.mem_reads += 1 + w_mem;
            end
            7'h23: begin e.cycles += 4 + w_mem; e.aow = 2; e.mw = 1 + w_mem; e.iod = 1 + w_mem; end
            7'h63: begin
                if (bc) begin e.cycles += 3; e.pc_src = 1'b1; e.pcw_ctrl = 4'b1001; end
                else    e.cycles += 4;
            end
            7'h6F: begin e.cycles += 3; e.reg_writes = 1; e.wb_sel = 2'b10; e.pc_src = 1'b1; end
            default: e.cycles += 3;
        endcase
        return e;
    endfunction

    // Runs one instruction to retirement, tallying what the DUT did, then scores it.
    task automatic applyStimulus(input logic [6:0] op, input logic bc, input int w_if, input int w_mem);
        exp_t e, o;
        bit   done;
        sb_q.push_back(expectFor(op, bc, w_if, w_mem));
        o = '{default: 0};
        done = 0;
        opcode = op; bcond = bc; halt_req = 1'b0;
        for (int c = 1; c <= 64 && !done; c++) begin
            mem_ready = !((c <= w_if) || (c >= w_if + 4 && c < w_if + 4 + w_mem));
            #1;
            o.mem_reads  += int'(mem_read);
            o.ir_writes  += int'(ir_write);
            o.aow        += int'(alu_out_write);
            o.iod        += int'(i_or_d);
            o.mdr        += int'(mdr_write);
            o.mw         += int'(mem_write);
            o.reg_writes += int'(reg_write);
            o.pc_writes  += int'(pc_write);
            if (reg_write) o.wb_sel = wb_sel;
            if (pc_write) begin
                o.pc_src   = pc_source;
                o.pcw_ctrl = {alu_src_a, alu_src_b, ALU_op_sig};
            end
            if (retire) begin
                done = 1;
                o.cycles = c;
            end
            @(negedge clk);
        end
        e = sb_q.pop_front();
        checkOutput($sformatf("retire_seen_op%02h", op), 32'(done), 32'd1);
        checkOutput($sformatf("cycles_op%02h", op), 32'(o.cycles), 32'(e.cycles));
        checkOutput($sformatf("mem_reads_op%02h", op), 32'(o.mem_reads), 32'(e.mem_reads));
        checkOutput($sformatf("ir_writes_op%02h", op), 32'(o.ir_writes), 32'(e.ir_writes));
        checkOutput($sformatf("alu_out_writes_op%02h", op), 32'(o.aow), 32'(e.aow));
        checkOutput($sformatf("i_or_d_op%02h", op), 32'(o.iod), 32'(e.iod));
        checkOutput($sformatf("mdr_writes_op%02h", op), 32'(o.mdr), 32'(e.mdr));
        checkOutput($sformatf("mem_write_cycles_op%02h", op), 32'(o.mw), 32'(e.mw));
        checkOutput($sformatf("reg_writes_op%02h", op), 32'(o.reg_writes), 32'(e.reg_writes));
        checkOutput($sformatf("pc_writes_op%02h", op), 32'(o.pc_writes), 32'(e.pc_writes));
        checkOutput($sformatf("wb_sel_op%02h", op), 32'(o.wb_sel), 32'(e.wb_sel));
        checkOutput($sformatf("pc_source_op%02h", op), 32'(o.pc_src), 32'(e.pc_src));
        checkOutput($sformatf("pc_write_ctrl_op%02h", op), 32'(o.pcw_ctrl), 32'(e.pcw_ctrl));
    endtask

    // Pulses reset for one cycle starting and ending on a falling edge.
    task automatic resetDut();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Main sequence: reset state, instruction mix, then halt/error/reset corner cases.
    initial begin
        int first_halt;
        int halted_cycles;
        int enables_seen;
        int writes_seen;
        logic at16;

        reset = 1'b1; opcode = 7'h33; bcond = 1'b1; halt_req = 1'b1; mem_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1 checkOutput("reset_outputs_zero", 32'(all_outs), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        applyStimulus(7'h33, 1'b0, 0, 0);
        applyStimulus(7'h13, 1'b0, 0, 0);
        applyStimulus(7'h67, 1'b0, 0, 0);
        applyStimulus(7'h03, 1'b0, 0, 0);
        applyStimulus(7'h03, 1'b0, 0, 3);
        applyStimulus(7'h23, 1'b0, 0, 0);
        applyStimulus(7'h23, 1'b0, 2, 2);
        applyStimulus(7'h63, 1'b1, 0, 0);
        applyStimulus(7'h63, 1'b0, 0, 0);
        applyStimulus(7'h6F, 1'b0, 0, 0);
        applyStimulus(7'h73, 1'b0, 0, 0);
        applyStimulus(7'h37, 1'b0, 0, 0);
        applyStimulus(7'h33, 1'b0, 15, 0);
        applyStimulus(7'h03, 1'b1, 1, 15);

        // ECALL with halt request: HALT right after ID and stuck there.
        resetDut();
        opcode = 7'h73; halt_req = 1'b1; bcond = 1'b0;
        first_halt = 0; halted_cycles = 0; enables_seen = 0;
        for (int c = 1; c <= 25; c++) begin
            mem_ready = (c % 3) != 0;
            #1;
            if (is_halted && first_halt == 0) first_halt = c;
            if (is_halted) halted_cycles++;
            if (c >= 3 && (pc_write | mem_read | mem_write | ir_write | mdr_write |
                           alu_out_write | reg_write | retire)) enables_seen++;
            @(negedge clk);
        end
        checkOutput("ecall_halt_cycle", 32'(first_halt), 32'd3);
        checkOutput("ecall_halted_cycles", 32'(halted_cycles), 32'd23);
        checkOutput("ecall_halt_enables", 32'(enables_seen), 32'd0);
        checkOutput("ecall_no_mem_error", 32'(mem_error), 32'd0);

        // Fetch that never completes: watchdog fires on the 16th wait cycle.
        resetDut();
        opcode = 7'h33; halt_req = 1'b0; mem_ready = 1'b0;
        first_halt = 0; at16 = 1'b0; halted_cycles = 0;
        for (int c = 1; c <= 40; c++) begin
            if (c == 30) mem_ready = 1'b1;
            #1;
            if (is_halted && first_halt == 0) first_halt = c;
            if (c == 16) at16 = mem_read && !mem_error && !is_halted;
            if (c >= 17 && is_halted && mem_error) halted_cycles++;
            @(negedge clk);
        end
        checkOutput("memerr_still_fetching_c16", 32'(at16), 32'd1);
        checkOutput("memerr_halt_cycle", 32'(first_halt), 32'd17);
        checkOutput("memerr_sticky_cycles", 32'(halted_cycles), 32'd24);

        // Reset arriving while a store waits in MEM aborts it cleanly.
        resetDut();
        opcode = 7'h23; halt_req = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            mem_ready = 1'b1;
            @(negedge clk);
        end
        mem_ready = 1'b0;
        #1 checkOutput("sw_mem_write_before_reset", 32'(mem_write), 32'd1);
        #2 reset = 1'b1;
        #1 checkOutput("sw_reset_outputs_zero", 32'(all_outs), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1 checkOutput("sw_restart_in_if", 32'({mem_read, i_or_d, mem_write}), 32'b100);
        writes_seen = 0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            #1 writes_seen += int'(mem_write);
        end
        checkOutput("sw_no_write_after_reset", 32'(writes_seen), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Safety net in case the sequence above ever stops advancing.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
